// File: rtl/decode_stage_pkg.sv
// Shared types for the pipelined decode stage.
//   - opcode, pc_sel, reg_wr_sel, ALU operand/operator encodings as used by the
//     single-cycle core
//   - imm_sel: immediate format selector consumed by decode_stage_imm_gen
//   - OPC_R funct7 constants
//   - ctrl_t: decoded control bundle held in the pipeline register
package decode_stage_pkg;

  typedef logic [31:0] instr_t;

  typedef enum logic [6:0] {
    OPC_LUI   = 7'b0110111,
    OPC_AUIPC = 7'b0010111,
    OPC_JAL   = 7'b1101111,
    OPC_JALR  = 7'b1100111,
    OPC_B     = 7'b1100011,
    OPC_LOAD  = 7'b0000011,
    OPC_S     = 7'b0100011,
    OPC_I     = 7'b0010011,
    OPC_R     = 7'b0110011
  } opcode_t;

  typedef enum logic [1:0] {
    PC_INCR    = 2'd0,
    PC_IMM_OFF = 2'd1,
    PC_ALU_OUT = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    REG_WR_ALU_OUT = 2'd0,
    REG_WR_MEM     = 2'd1,
    REG_WR_PC_INCR = 2'd2,
    REG_WR_IMM     = 2'd3
  } reg_wr_sel_t;

  typedef enum logic {
    ALU_OPND_1_RS1 = 1'b0,
    ALU_OPND_1_PC  = 1'b1
  } alu_opnd_1_sel_t;

  typedef enum logic {
    ALU_OPND_2_RS2 = 1'b0,
    ALU_OPND_2_IMM = 1'b1
  } alu_opnd_2_sel_t;

  // ALU operator is {alt, funct3}; branches reuse SUB/SLT/SLTU slots as
  // {2'b10, funct3[2:1]}, so it is kept as a plain vector.
  typedef logic [3:0] alu_optr_t;
  localparam alu_optr_t ALU_ADD = 4'b0000;

  typedef enum logic [2:0] {
    IMM_I       = 3'd0,
    IMM_I_SHIFT = 3'd1,
    IMM_S       = 3'd2,
    IMM_B       = 3'd3,
    IMM_U       = 3'd4,
    IMM_JAL     = 3'd5
  } imm_sel_t;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    pc_sel_t         pc_sel;
    logic            is_branch;
    logic            br_pol;
    reg_wr_sel_t     reg_wr_sel;
    logic            reg_wr_en;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    alu_opnd_1_sel_t alu_opnd_1_sel;
    alu_opnd_2_sel_t alu_opnd_2_sel;
    alu_optr_t       alu_optr;
    logic            md_en;
    logic [2:0]      md_op;
    logic            is_load;
    logic            mem_wr_en;
    logic            illegal;
  } ctrl_t;

  // Only these formats actually read rs2; others carry immediate bits there.
  function automatic logic opc_uses_rs2(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_S) || (opc == OPC_B);
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: assembles the immediate for the selected format and
// sign-extends it to DATA_WIDTH (shift amounts are zero-extended).
// Ports:
//   instr   - instruction bits [31:7] (opcode bits are not needed here)
//   imm_sel - immediate format
//   imm     - DATA_WIDTH immediate
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:7]           instr,
  input  imm_sel_t              imm_sel,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I:       imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_I_SHIFT: imm32 = {27'd0, instr[24:20]};
      IMM_S:       imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:       imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
      IMM_U:       imm32 = {instr[31:12], 12'd0};
      IMM_JAL:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
      default:     imm32 = '0;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage between fetch and execute.
// Decodes RV32I (plus RV32M when SUPPORT_M=1) into control fields and an
// immediate, with valid/ready on both sides, flush, load-use bubble insertion,
// illegal-instruction flagging and a saturating hazard-stall counter.
// Ports:
//   i_clk, i_rst          - clock, synchronous active-high reset
//   i_instr, i_valid      - fetched instruction and its valid
//   o_ready               - instruction accepted this cycle
//   i_ready               - execute accepts the output this cycle
//   i_flush               - kill in-flight and incoming instruction
//   o_valid .. o_illegal  - registered decode result
//   o_stall_cnt           - number of hazard bubbles inserted (saturating)
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SUPPORT_M       = 0,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  instr_t                     i_instr,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_ready,
  input  logic                       i_flush,
  output logic                       o_valid,
  output pc_sel_t                    o_pc_sel,
  output logic                       o_is_branch,
  output logic                       o_br_pol,
  output reg_wr_sel_t                o_reg_wr_sel,
  output logic                       o_reg_wr_en,
  output logic [4:0]                 o_rd,
  output logic [4:0]                 o_rs1,
  output logic [4:0]                 o_rs2,
  output alu_opnd_1_sel_t            o_alu_opnd_1_sel,
  output alu_opnd_2_sel_t            o_alu_opnd_2_sel,
  output alu_optr_t                  o_alu_optr,
  output logic                       o_md_en,
  output logic [2:0]                 o_md_op,
  output logic                       o_is_load,
  output logic                       o_mem_wr_en,
  output logic [DATA_WIDTH-1:0]      o_imm,
  output logic                       o_illegal,
  output logic [STALL_CNT_WIDTH-1:0] o_stall_cnt
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opc = i_instr[6:0];
  assign rd  = i_instr[11:7];
  assign f3  = i_instr[14:12];
  assign rs1 = i_instr[19:15];
  assign rs2 = i_instr[24:20];
  assign f7  = i_instr[31:25];

  ctrl_t                      dec;
  ctrl_t                      ctrl_q;
  imm_sel_t                   imm_sel;
  logic                       legal;
  logic [DATA_WIDTH-1:0]      imm_dec;
  logic [DATA_WIDTH-1:0]      imm_q;
  logic                       valid_q;
  logic [STALL_CNT_WIDTH-1:0] cnt_q;
  logic                       hazard;
  logic                       advance;
  logic                       accept;

  always_comb begin
    dec     = '0;
    dec.rd  = rd;
    dec.rs1 = rs1;
    dec.rs2 = rs2;
    imm_sel = IMM_I;
    legal   = 1'b1;
    case (opc)
      OPC_LUI: begin
        dec.reg_wr_en  = 1'b1;
        dec.reg_wr_sel = REG_WR_IMM;
        imm_sel        = IMM_U;
      end
      OPC_AUIPC: begin
        dec.reg_wr_en      = 1'b1;
        dec.alu_opnd_1_sel = ALU_OPND_1_PC;
        dec.alu_opnd_2_sel = ALU_OPND_2_IMM;
        imm_sel            = IMM_U;
      end
      OPC_JAL: begin
        dec.reg_wr_en  = 1'b1;
        dec.reg_wr_sel = REG_WR_PC_INCR;
        dec.pc_sel     = PC_IMM_OFF;
        imm_sel        = IMM_JAL;
      end
      OPC_JALR: begin
        dec.reg_wr_en      = 1'b1;
        dec.reg_wr_sel     = REG_WR_PC_INCR;
        dec.pc_sel         = PC_ALU_OUT;
        dec.alu_opnd_2_sel = ALU_OPND_2_IMM;
      end
      OPC_B: begin
        // Execute resolves taken = zero ^ br_pol; pc_sel stays INCR here.
        dec.is_branch = 1'b1;
        dec.br_pol    = f3[2] ^ f3[0];
        dec.alu_optr  = {2'b10, f3[2:1]};
        imm_sel       = IMM_B;
      end
      OPC_LOAD: begin
        dec.is_load        = 1'b1;
        dec.reg_wr_en      = 1'b1;
        dec.reg_wr_sel     = REG_WR_MEM;
        dec.alu_opnd_2_sel = ALU_OPND_2_IMM;
      end
      OPC_S: begin
        dec.mem_wr_en      = 1'b1;
        dec.alu_opnd_2_sel = ALU_OPND_2_IMM;
        imm_sel            = IMM_S;
      end
      OPC_I: begin
        dec.reg_wr_en      = 1'b1;
        dec.alu_opnd_2_sel = ALU_OPND_2_IMM;
        dec.alu_optr       = {(f3 == 3'b101) & f7[5], f3};
        if (f3 == 3'b001 || f3 == 3'b101) imm_sel = IMM_I_SHIFT;
      end
      OPC_R: begin
        dec.reg_wr_en = 1'b1;
        dec.alu_optr  = {f7[5], f3};
        if (f7 == F7_MULDIV) begin
          if (SUPPORT_M != 0) begin
            dec.md_en = 1'b1;
            dec.md_op = f3;
          end else begin
            legal = 1'b0;
          end
        end else if (f7 == F7_ALT) begin
          // Only SUB and SRA have an alternate encoding.
          legal = (f3 == 3'b000) || (f3 == 3'b101);
        end else if (f7 != F7_BASE) begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.rd      = rd;
      dec.rs1     = rs1;
      dec.rs2     = rs2;
      dec.illegal = 1'b1;
    end
  end

  decode_stage_imm_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_imm_gen (
    .instr  (i_instr[31:7]),
    .imm_sel(imm_sel),
    .imm    (imm_dec)
  );

  // Load-use: the load in the output register has not produced data yet.
  // rs1 is compared for every opcode; rs2 only where it is a real source.
  assign hazard = valid_q && ctrl_q.is_load && (ctrl_q.rd != 5'd0) && i_valid &&
                  ((rs1 == ctrl_q.rd) || (opc_uses_rs2(opc) && (rs2 == ctrl_q.rd)));
  assign advance = !valid_q || i_ready;
  assign o_ready = advance && !hazard && !i_flush;
  assign accept  = o_ready && i_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      imm_q   <= '0;
      cnt_q   <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      imm_q   <= '0;
    end else if (advance) begin
      valid_q <= accept;
      if (accept) begin
        ctrl_q <= dec;
        imm_q  <= imm_dec;
      end else begin
        ctrl_q <= '0;
        imm_q  <= '0;
      end
      if (hazard && (cnt_q != '1)) cnt_q <= cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  assign o_valid          = valid_q;
  assign o_pc_sel         = ctrl_q.pc_sel;
  assign o_is_branch      = ctrl_q.is_branch;
  assign o_br_pol         = ctrl_q.br_pol;
  assign o_reg_wr_sel     = ctrl_q.reg_wr_sel;
  assign o_reg_wr_en      = ctrl_q.reg_wr_en;
  assign o_rd             = ctrl_q.rd;
  assign o_rs1            = ctrl_q.rs1;
  assign o_rs2            = ctrl_q.rs2;
  assign o_alu_opnd_1_sel = ctrl_q.alu_opnd_1_sel;
  assign o_alu_opnd_2_sel = ctrl_q.alu_opnd_2_sel;
  assign o_alu_optr       = ctrl_q.alu_optr;
  assign o_md_en          = ctrl_q.md_en;
  assign o_md_op          = ctrl_q.md_op;
  assign o_is_load        = ctrl_q.is_load;
  assign o_mem_wr_en      = ctrl_q.mem_wr_en;
  assign o_illegal        = ctrl_q.illegal;
  assign o_imm            = imm_q;
  assign o_stall_cnt      = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances share one stimulus stream
// (index 0: SUPPORT_M=1, 2-bit stall counter; index 1: SUPPORT_M=0, 16-bit).
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        vin;
  logic        rdy;
  logic        flush;

  logic            valid_o    [2];
  logic            ready_o    [2];
  pc_sel_t         pc_sel_o   [2];
  logic            is_branch_o[2];
  logic            br_pol_o   [2];
  reg_wr_sel_t     wr_sel_o   [2];
  logic            wr_en_o    [2];
  logic [4:0]      rd_o       [2];
  logic [4:0]      rs1_o      [2];
  logic [4:0]      rs2_o      [2];
  alu_opnd_1_sel_t op1_o      [2];
  alu_opnd_2_sel_t op2_o      [2];
  alu_optr_t       optr_o     [2];
  logic            md_en_o    [2];
  logic [2:0]      md_op_o    [2];
  logic            is_load_o  [2];
  logic            mem_wr_o   [2];
  logic [31:0]     imm_o      [2];
  logic            illegal_o  [2];
  logic [1:0]      cnt_m;
  logic [15:0]     cnt_n;

  decode_stage #(.DATA_WIDTH(32), .SUPPORT_M(1), .STALL_CNT_WIDTH(2)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_valid(vin), .o_ready(ready_o[0]),
    .i_ready(rdy), .i_flush(flush), .o_valid(valid_o[0]), .o_pc_sel(pc_sel_o[0]),
    .o_is_branch(is_branch_o[0]), .o_br_pol(br_pol_o[0]), .o_reg_wr_sel(wr_sel_o[0]),
    .o_reg_wr_en(wr_en_o[0]), .o_rd(rd_o[0]), .o_rs1(rs1_o[0]), .o_rs2(rs2_o[0]),
    .o_alu_opnd_1_sel(op1_o[0]), .o_alu_opnd_2_sel(op2_o[0]), .o_alu_optr(optr_o[0]),
    .o_md_en(md_en_o[0]), .o_md_op(md_op_o[0]), .o_is_load(is_load_o[0]),
    .o_mem_wr_en(mem_wr_o[0]), .o_imm(imm_o[0]), .o_illegal(illegal_o[0]),
    .o_stall_cnt(cnt_m));

  decode_stage #(.DATA_WIDTH(32), .SUPPORT_M(0), .STALL_CNT_WIDTH(16)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_valid(vin), .o_ready(ready_o[1]),
    .i_ready(rdy), .i_flush(flush), .o_valid(valid_o[1]), .o_pc_sel(pc_sel_o[1]),
    .o_is_branch(is_branch_o[1]), .o_br_pol(br_pol_o[1]), .o_reg_wr_sel(wr_sel_o[1]),
    .o_reg_wr_en(wr_en_o[1]), .o_rd(rd_o[1]), .o_rs1(rs1_o[1]), .o_rs2(rs2_o[1]),
    .o_alu_opnd_1_sel(op1_o[1]), .o_alu_opnd_2_sel(op2_o[1]), .o_alu_optr(optr_o[1]),
    .o_md_en(md_en_o[1]), .o_md_op(md_op_o[1]), .o_is_load(is_load_o[1]),
    .o_mem_wr_en(mem_wr_o[1]), .o_imm(imm_o[1]), .o_illegal(illegal_o[1]),
    .o_stall_cnt(cnt_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    bit [1:0]  pc_sel;
    bit        is_branch;
    bit        br_pol;
    bit [1:0]  wr_sel;
    bit        wr_en;
    bit [4:0]  rd;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit        op1;
    bit        op2;
    bit [3:0]  optr;
    bit        md_en;
    bit [2:0]  md_op;
    bit        is_load;
    bit        mem_wr;
    bit        illegal;
    bit [31:0] imm;
  } mdl_t;

  mdl_t exp_dec   [2];
  bit   exp_valid [2];
  int   exp_cnt   [2];
  logic last_ready[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference decode straight from the ISA rules, immediates built arithmetically.
  function automatic mdl_t model_decode(input bit [31:0] ins, input bit supm);
    mdl_t   m;
    int     opc, f3, f7;
    bit     ok;
    longint si, imm;
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    si  = longint'($signed(ins));
    m   = '0;
    ok  = 1'b1;
    imm = si >>> 20;
    case (opc)
      'h37: begin m.wr_en = 1; m.wr_sel = REG_WR_IMM; imm = (si >>> 12) << 12; end
      'h17: begin m.wr_en = 1; m.op1 = 1; m.op2 = 1; imm = (si >>> 12) << 12; end
      'h6F: begin
        m.wr_en = 1; m.wr_sel = REG_WR_PC_INCR; m.pc_sel = PC_IMM_OFF;
        imm = ((si >>> 31) << 20) | (longint'(ins[19:12]) << 12) |
              (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      end
      'h67: begin m.wr_en = 1; m.wr_sel = REG_WR_PC_INCR; m.pc_sel = PC_ALU_OUT; m.op2 = 1; end
      'h63: begin
        m.is_branch = 1;
        m.br_pol    = 1'((f3 >> 2) ^ f3);
        m.optr      = 4'(8 + (f3 >> 1));
        imm = ((si >>> 31) << 12) | (longint'(ins[7]) << 11) |
              (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      end
      'h03: begin m.is_load = 1; m.wr_en = 1; m.wr_sel = REG_WR_MEM; m.op2 = 1; end
      'h23: begin m.mem_wr = 1; m.op2 = 1; imm = ((si >>> 25) << 5) | longint'(ins[11:7]); end
      'h13: begin
        m.wr_en = 1; m.op2 = 1;
        m.optr  = 4'(f3 + ((f3 == 5 && (f7 & 32) != 0) ? 8 : 0));
        if (f3 == 1 || f3 == 5) imm = longint'(ins[24:20]);
      end
      'h33: begin
        m.wr_en = 1;
        m.optr  = 4'(f3 + (((f7 & 32) != 0) ? 8 : 0));
        if (f7 == 1) begin
          ok = supm;
          m.md_en = 1; m.md_op = 3'(f3);
        end else if (f7 == 'h20) begin
          ok = (f3 == 0 || f3 == 5);
        end else begin
          ok = (f7 == 0);
        end
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      m = '0;
      m.illegal = 1;
    end
    m.rd  = ins[11:7];
    m.rs1 = ins[19:15];
    m.rs2 = ins[24:20];
    m.imm = imm[31:0];
    return m;
  endfunction

  function automatic bit model_hazard(input int k, input bit v, input bit [31:0] ins);
    int opc;
    opc = int'(ins[6:0]);
    return exp_valid[k] && exp_dec[k].is_load && exp_dec[k].rd != 0 && v &&
           (ins[19:15] == exp_dec[k].rd ||
            ((opc == 'h33 || opc == 'h23 || opc == 'h63) && ins[24:20] == exp_dec[k].rd));
  endfunction

  task automatic compare_outputs();
    for (int k = 0; k < 2; k++) begin
      string t;
      t = (k == 0) ? "m1" : "m0";
      chk({t, " valid"}, valid_o[k], exp_valid[k]);
      chk({t, " stall_cnt"}, (k == 0) ? 64'(cnt_m) : 64'(cnt_n), exp_cnt[k]);
      chk({t, " illegal"}, illegal_o[k], exp_dec[k].illegal);
      chk({t, " reg_wr_en"}, wr_en_o[k], exp_dec[k].wr_en);
      chk({t, " mem_wr_en"}, mem_wr_o[k], exp_dec[k].mem_wr);
      chk({t, " md_en"}, md_en_o[k], exp_dec[k].md_en);
      chk({t, " is_branch"}, is_branch_o[k], exp_dec[k].is_branch);
      chk({t, " is_load"}, is_load_o[k], exp_dec[k].is_load);
      if (exp_valid[k]) begin
        chk({t, " pc_sel"}, pc_sel_o[k], exp_dec[k].pc_sel);
        chk({t, " br_pol"}, br_pol_o[k], exp_dec[k].br_pol);
        chk({t, " reg_wr_sel"}, wr_sel_o[k], exp_dec[k].wr_sel);
        chk({t, " rd"}, rd_o[k], exp_dec[k].rd);
        chk({t, " rs1"}, rs1_o[k], exp_dec[k].rs1);
        chk({t, " rs2"}, rs2_o[k], exp_dec[k].rs2);
        chk({t, " opnd_1"}, op1_o[k], exp_dec[k].op1);
        chk({t, " opnd_2"}, op2_o[k], exp_dec[k].op2);
        chk({t, " alu_optr"}, optr_o[k], exp_dec[k].optr);
        chk({t, " md_op"}, md_op_o[k], exp_dec[k].md_op);
        chk({t, " imm"}, imm_o[k], exp_dec[k].imm);
      end
    end
  endtask

  // One clock: drive at negedge, check o_ready before the edge, advance the
  // model at the edge, check registered outputs just after it.
  task automatic step(input bit r, input bit v, input bit [31:0] ins, input bit rd_in,
                      input bit fl);
    bit adv, haz, exp_rdy;
    @(negedge clk);
    rst = r; vin = v; instr = ins; rdy = rd_in; flush = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      last_ready[k] = ready_o[k];
      if (!r) begin
        adv     = !exp_valid[k] || rd_in;
        haz     = model_hazard(k, v, ins);
        exp_rdy = adv && !haz && !fl;
        chk((k == 0) ? "m1 ready" : "m0 ready", ready_o[k], exp_rdy);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        exp_valid[k] = 0; exp_dec[k] = '0; exp_cnt[k] = 0;
      end else begin
        adv = !exp_valid[k] || rd_in;
        haz = model_hazard(k, v, ins);
        if (fl) begin
          exp_valid[k] = 0; exp_dec[k] = '0;
        end else if (adv) begin
          if (haz) begin
            exp_valid[k] = 0; exp_dec[k] = '0;
            if (exp_cnt[k] < ((k == 0) ? 3 : 65535)) exp_cnt[k]++;
          end else if (v) begin
            exp_valid[k] = 1; exp_dec[k] = model_decode(ins, k == 0);
          end else begin
            exp_valid[k] = 0; exp_dec[k] = '0;
          end
        end
      end
    end
    #1;
    compare_outputs();
  endtask

  function automatic bit [31:0] rand_instr();
    bit [31:0] ins;
    int        sel;
    ins = $urandom();
    sel = $urandom_range(0, 11);
    case (sel)
      0: ins[6:0] = 7'h37;  1: ins[6:0] = 7'h17;  2: ins[6:0] = 7'h6F;
      3: ins[6:0] = 7'h67;  4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h23;
      6: ins[6:0] = 7'h13;  7: ins[6:0] = 7'h33;  8: ins[6:0] = 7'h33;
      9: ins[6:0] = ins[6:0];
      default: ins[6:0] = 7'h03;
    endcase
    case ($urandom_range(0, 3))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      2: ins[31:25] = 7'h01;
      default: ins[31:25] = ins[31:25];
    endcase
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  localparam bit [31:0] ADDI = 32'h00500093;
  localparam bit [31:0] LW2  = 32'h0000A103;
  localparam bit [31:0] ADD3 = 32'h001101B3;
  localparam bit [31:0] LW0  = 32'h0000A003;
  localparam bit [31:0] ADD0 = 32'h001001B3;
  localparam bit [31:0] BEQ  = 32'h00208463;
  localparam bit [31:0] BNE  = 32'h00209463;
  localparam bit [31:0] JAL  = 32'hFFDFF0EF;
  localparam bit [31:0] MUL  = 32'h022081B3;
  localparam bit [31:0] BAD  = 32'h0000007F;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; vin = 1'b0; instr = '0; rdy = 1'b0; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_valid[k] = 0; exp_dec[k] = '0; exp_cnt[k] = 0;
    end

    step(1, 1, ADDI, 1, 0);
    step(1, 0, 32'h0, 0, 0);
    chk("reset valid", valid_o[0], 0);
    chk("reset stall_cnt", cnt_n, 0);
    chk("reset pc_sel", pc_sel_o[0], 0);
    chk("reset imm", imm_o[1], 0);
    chk("reset illegal", illegal_o[0], 0);

    step(0, 1, ADDI, 1, 0);
    chk("addi imm", imm_o[0], 5);
    chk("addi rd", rd_o[0], 1);
    chk("addi wr_en", wr_en_o[0], 1);
    chk("addi opnd_2", op2_o[0], ALU_OPND_2_IMM);

    step(0, 1, LW2, 1, 0);
    step(0, 1, ADD3, 1, 0);
    chk("load-use ready", last_ready[0], 0);
    chk("load-use bubble", valid_o[0], 0);
    step(0, 1, ADD3, 1, 0);
    chk("after bubble valid", valid_o[0], 1);
    chk("after bubble rd", rd_o[0], 3);
    chk("stall_cnt one", cnt_n, 1);
    step(0, 1, LW0, 1, 0);
    step(0, 1, ADD0, 1, 0);
    chk("x0 load ready", last_ready[0], 1);
    chk("x0 load valid", valid_o[0], 1);

    for (int i = 0; i < 3; i++) begin
      step(0, 1, LW2, 1, 0);
      step(0, 1, ADD3, 1, 0);
      step(0, 1, ADD3, 1, 0);
    end
    chk("stall_cnt saturated", cnt_m, 3);
    chk("stall_cnt wide", cnt_n, 4);

    step(0, 1, BEQ, 1, 0);
    chk("beq is_branch", is_branch_o[0], 1);
    chk("beq br_pol", br_pol_o[0], 0);
    chk("beq imm", imm_o[0], 8);
    chk("beq optr", optr_o[0], 4'b1000);
    step(0, 1, BNE, 1, 0);
    chk("bne br_pol", br_pol_o[0], 1);

    step(0, 1, JAL, 1, 0);
    chk("jal imm", imm_o[0], 32'hFFFFFFFC);
    chk("jal pc_sel", pc_sel_o[0], PC_IMM_OFF);
    chk("jal wr_sel", wr_sel_o[0], REG_WR_PC_INCR);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, ADDI, 0, 0);
      chk("hold ready", last_ready[0], 0);
      chk("hold imm", imm_o[0], 32'hFFFFFFFC);
      chk("hold pc_sel", pc_sel_o[1], PC_IMM_OFF);
    end
    step(0, 1, ADDI, 1, 0);

    step(0, 1, MUL, 1, 0);
    chk("mul md_en", md_en_o[0], 1);
    chk("mul md_op", md_op_o[0], 0);
    chk("mul wr_en", wr_en_o[0], 1);
    chk("mul noM illegal", illegal_o[1], 1);
    chk("mul noM wr_en", wr_en_o[1], 0);
    step(0, 1, BAD, 1, 0);
    chk("bad opcode illegal", illegal_o[0], 1);
    chk("bad opcode valid", valid_o[0], 1);

    step(0, 1, ADDI, 1, 0);
    step(0, 0, 32'h0, 0, 0);
    step(0, 1, ADD3, 0, 1);
    chk("flush ready", last_ready[0], 0);
    chk("flush valid", valid_o[0], 0);
    step(0, 0, 32'h0, 1, 0);
    chk("flushed not taken", valid_o[1], 0);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 8, rand_instr(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the pipelined core; sits between fetch and execute.
- Decodes RV32I (and optionally RV32M) into the existing control enums and a sign-extended immediate.
- Adds behaviour the single-cycle decoder lacks:
  - valid/ready handshakes on both sides
  - flush
  - load-use hazard stall with bubble insertion
  - illegal-instruction flagging
  - saturating stall counter
- Branch resolution moves to execute: this stage emits branch polarity instead of consuming the zero flag.

Parameters:
- DATA_WIDTH, 32, width of immediate and PC-related data outputs; must be ≥32; immediates sign-extend to this width.
- SUPPORT_M, 0, 1 enables RV32M decode (funct7=0000001 on OPC_R); 0 flags those encodings illegal.
- STALL_CNT_WIDTH, 16, width of the saturating hazard-stall counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_instr  in  32 (instr)  fetched instruction
- i_valid  in  1  fetch holds a valid instruction
- o_ready  out  1  stage accepts i_instr this cycle
- i_ready  in  1  execute accepts output this cycle
- i_flush  in  1  kill in-flight and incoming instruction
- o_valid  out  1  output registers hold a valid decoded instruction
- o_pc_sel  out  pc_sel  PC_INCR / PC_IMM_OFF / PC_ALU_OUT
- o_is_branch  out  1  conditional branch; execute computes taken = zero ^ o_br_pol
- o_br_pol  out  1  funct3[2] ^ funct3[0]
- o_reg_wr_sel  out  reg_wr_sel  register write source
- o_reg_wr_en  out  1  register write enable
- o_rd, o_rs1, o_rs2  out  5 each  register addresses
- o_alu_opnd_1_sel  out  alu_opnd_1_sel  ALU operand 1 source
- o_alu_opnd_2_sel  out  alu_opnd_2_sel  ALU operand 2 source
- o_alu_optr  out  alu_optr  ALU operator, encoded as in single-cycle core
- o_md_en  out  1  mul/div op (always 0 when SUPPORT_M=0)
- o_md_op  out  3  funct3 of mul/div op
- o_is_load  out  1  load instruction
- o_mem_wr_en  out  1  store
- o_imm  out  DATA_WIDTH  decoded immediate
- o_illegal  out  1  undecodable instruction
- o_stall_cnt  out  STALL_CNT_WIDTH  count of hazard-bubble cycles

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst is synchronous, active-high.
- Reset values:
  - o_valid=0, o_stall_cnt=0
  - all control outputs 0, i.e. o_pc_sel=PC_INCR with writes and enables deasserted
  - o_imm=0, o_illegal=0
- Latency: 1 cycle. A fire (i_valid & o_ready) at edge N makes o_valid=1 with decoded fields after edge N.
- Readiness: advance = ~o_valid | i_ready; o_ready = advance & ~hazard & ~i_flush.
- Hazard: o_valid & o_is_load & o_rd≠0 & i_valid, and incoming rs1==o_rd or (uses_rs2 & rs2==o_rd).
  - uses_rs2 is true for OPC_R, OPC_S and OPC_B only.
- On hazard with i_ready=1:
  - output register loads a bubble (o_valid=0, all enables 0)
  - input is held (o_ready=0)
  - o_stall_cnt increments, saturating at all-ones
- On hazard with i_ready=0: output holds; no count.
- Output hold: with o_valid & ~i_ready, all outputs stay stable.
- Flush: i_flush=1 forces o_valid=0 next cycle and o_ready=0, so nothing is accepted that cycle. Flush overrides hazard and hold; the counter does not increment.
- Decode table: per opcode, identical to the single-cycle decoder.
  - I-type shifts (SLL/SRL) use the 5-bit zero-extended shamt.
  - SRA/SRAI set o_alu_optr[3] from funct7[5].
  - Branches use o_alu_optr = {2'b10, funct3[2:1]}.
  - Loads, stores, AUIPC and JALR use add.
- Illegal: any of the following sets o_illegal=1 with o_valid=1, forces o_reg_wr_en=0, o_mem_wr_en=0, o_pc_sel=PC_INCR, o_md_en=0.
  - unknown opcode
  - OPC_R with funct7 not in {0000000, 0100000 (ADD/SUB, SRL/SRA only)}
  - OPC_R with funct7 = 0000001 when SUPPORT_M=0
- Register fields: o_rs1/o_rs2/o_rd are passed through raw for every opcode; consumers gate them with enables.
- Bubble cycles: o_valid=0 with o_illegal=0.

Decomposition:
- Shared package holds:
  - existing opcode, pc_sel, reg_wr_sel, alu_opnd_*_sel, alu_optr, instr types
  - new imm_sel enum (I, I_SHIFT, S, B, U, JAL)
  - OPC_R funct7 constants (F7_BASE, F7_ALT, F7_MULDIV)
- One combinational sub-module, imm_gen: inputs instr and imm_sel, output DATA_WIDTH immediate.
- Control decode, hazard logic, pipeline register and counter stay in decode_stage.

Test Plan:
- Reset, then i_valid=1 with 0x00500093 (addi x1,x0,5) and i_ready=1 → next cycle o_valid=1, o_imm=5, o_rd=1, o_reg_wr_en=1, o_alu_opnd_2_sel=ALU_OPND_2_IMM.
- 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1), i_ready=1 → one bubble cycle, o_ready=0 for that cycle, add emitted the following cycle, o_stall_cnt=1; repeat with rd=x0 → no bubble.
- 0x00208463 (beq, +8) → o_is_branch=1, o_br_pol=0, o_imm=8, o_alu_optr=4'b1000; 0x00209463 (bne) → o_br_pol=1.
- 0xFFDFF0EF (jal x1,-4) → o_imm=0xFFFFFFFC, o_pc_sel=PC_IMM_OFF, o_reg_wr_sel=REG_WR_PC_INCR; hold i_ready=0 for 3 cycles → outputs stable, o_ready=0.
- 0x022081B3 (mul): SUPPORT_M=1 → o_md_en=1, o_md_op=0, o_reg_wr_en=1; SUPPORT_M=0 → o_illegal=1, o_reg_wr_en=0; opcode 0x7F → o_illegal=1.
- Valid instruction in output with i_ready=0, then i_flush=1 for 1 cycle with new i_valid → o_valid=0 next cycle, new instruction not accepted; force saturation with STALL_CNT_WIDTH=2 → counter stays at 3.
